// File: rtl/dot_ctrl_pkg.sv
// Shared types and constants for the pellet-map controller: maze geometry,
// scoring, tile coordinates and the controller's FSM states.
package dot_ctrl_pkg;

  localparam logic [4:0] MAZE_ROWS  = 5'd31;
  localparam logic [4:0] MAZE_COLS  = 5'd28;
  localparam logic [5:0] DOT_PTS    = 6'd10;
  localparam logic [5:0] PELLET_PTS = 6'd50;
  // 31*28 tiles plus one slot to drain the ROM read pipeline
  localparam logic [9:0] SEED_LAST  = 10'd868;

  typedef struct packed {
    logic [4:0] row;
    logic [4:0] col;
  } tile_t;

  typedef enum logic [1:0] {SEED, RUN, EAT_RD, EAT_WR} dot_state_e;

  function automatic logic is_pellet(tile_t t);
    return ((t.row == 5'd3) || (t.row == 5'd23)) &&
           ((t.col == 5'd1) || (t.col == 5'd26));
  endfunction

  function automatic logic in_range(tile_t t);
    return (t.row < MAZE_ROWS) && (t.col < MAZE_COLS);
  endfunction

endpackage

// File: rtl/dot_ctrl_if.sv
// Bundle between the dot controller and its neighbours (wall ROM, renderer,
// game FSM), plus a debug view of the controller state.
interface dot_ctrl_if import dot_ctrl_pkg::*; ();
  // Eat handshake: eat_req is raised with a stable eat_row/eat_col and held
  // until eat_ack; eat_ack is a one-cycle pulse carrying eat_hit/eat_power/
  // eat_points, and the requester must drop or replace the request after it.
  logic        level_restart;
  logic [4:0]  rom_row;
  logic [4:0]  rom_col;
  logic        rom_wall;
  logic        render_en;
  logic [4:0]  render_row;
  logic [4:0]  render_col;
  logic        render_dot;
  logic        eat_req;
  logic [4:0]  eat_row;
  logic [4:0]  eat_col;
  logic        eat_ack;
  logic        eat_hit;
  logic        eat_power;
  logic [5:0]  eat_points;
  logic [9:0]  dots_remaining;
  logic        level_clear;
  logic        busy;
  dot_state_e  state;

  modport slave (
    input  level_restart, rom_wall, render_en, render_row, render_col,
           eat_req, eat_row, eat_col,
    output rom_row, rom_col, render_dot, eat_ack, eat_hit, eat_power,
           eat_points, dots_remaining, level_clear, busy, state
  );

  modport master (
    output level_restart, rom_wall, render_en, render_row, render_col,
           eat_req, eat_row, eat_col,
    input  rom_row, rom_col, render_dot, eat_ack, eat_hit, eat_power,
           eat_points, dots_remaining, level_clear, busy, state
  );
endinterface

// File: rtl/dot_ctrl_ram.sv
// Single-port 1024x1 dot map, synchronous 1-cycle read, write-first.
module dot_ctrl_ram (
  input  logic       clk,
  input  logic       we_i,
  input  logic [9:0] addr_i,
  input  logic       wdata_i,
  output logic       rdata_o
);
  logic mem [0:1023];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
      rdata_o     <= wdata_i;
    end else begin
      rdata_o <= mem[addr_i];
    end
  end
endmodule

// File: rtl/dot_ctrl.sv
// Pellet map owner: seeds dots from the wall ROM, arbitrates the single RAM
// port between renderer and eat requests, and tracks the remaining dot count.
module dot_ctrl import dot_ctrl_pkg::*; (
  input logic      clk,
  input logic      reset,
  dot_ctrl_if.slave bus
);
  dot_state_e state_q;
  logic [9:0] seed_cnt_q;
  tile_t      seed_tile_q, wr_tile_q, eat_tile_q;
  logic [9:0] dots_q;
  logic       level_clear_q, busy_q;
  logic       ack_q, hit_q, power_q, render_vld_q;
  logic [5:0] points_q;

  logic       ram_we, ram_wdata, ram_rdata;
  logic [9:0] ram_addr;
  tile_t      render_tile, eat_tile;
  logic       eat_hit_now;

  assign render_tile = {bus.render_row, bus.render_col};
  assign eat_tile    = {bus.eat_row, bus.eat_col};
  // Out-of-range tiles are never seeded, so their RAM bits are masked here.
  assign eat_hit_now = ram_rdata & in_range(eat_tile_q);

  always_comb begin
    ram_we    = 1'b0;
    ram_wdata = 1'b0;
    ram_addr  = eat_tile;
    unique case (state_q)
      SEED: begin
        ram_we    = (seed_cnt_q != 10'd0);
        ram_wdata = ~bus.rom_wall;
        ram_addr  = wr_tile_q;
      end
      RUN:     ram_addr = bus.render_en ? render_tile : eat_tile;
      EAT_RD:  ram_addr = eat_tile_q;
      EAT_WR: begin
        ram_we   = hit_q;
        ram_addr = eat_tile_q;
      end
      default: ;
    endcase
  end

  dot_ctrl_ram u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset || bus.level_restart) begin
      state_q       <= SEED;
      seed_cnt_q    <= '0;
      seed_tile_q   <= '0;
      wr_tile_q     <= '0;
      eat_tile_q    <= '0;
      dots_q        <= '0;
      level_clear_q <= 1'b0;
      busy_q        <= 1'b1;
      ack_q         <= 1'b0;
      hit_q         <= 1'b0;
      power_q       <= 1'b0;
      points_q      <= '0;
      render_vld_q  <= 1'b0;
    end else begin
      ack_q        <= 1'b0;
      hit_q        <= 1'b0;
      power_q      <= 1'b0;
      points_q     <= '0;
      render_vld_q <= 1'b0;
      case (state_q)
        SEED: begin
          // ROM answers one cycle late, so the write trails the address by one tile
          wr_tile_q  <= seed_tile_q;
          seed_cnt_q <= seed_cnt_q + 10'd1;
          if (seed_tile_q.col == MAZE_COLS - 5'd1) begin
            seed_tile_q.row <= seed_tile_q.row + 5'd1;
            seed_tile_q.col <= '0;
          end else begin
            seed_tile_q.col <= seed_tile_q.col + 5'd1;
          end
          if ((seed_cnt_q != 10'd0) && !bus.rom_wall) dots_q <= dots_q + 10'd1;
          if (seed_cnt_q == SEED_LAST) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.render_en) begin
            render_vld_q <= in_range(render_tile);
          end else if (bus.eat_req) begin
            eat_tile_q <= eat_tile;
            state_q    <= EAT_RD;
          end
        end
        EAT_RD: begin
          state_q  <= EAT_WR;
          ack_q    <= 1'b1;
          hit_q    <= eat_hit_now;
          power_q  <= eat_hit_now & is_pellet(eat_tile_q);
          points_q <= eat_hit_now ? (is_pellet(eat_tile_q) ? PELLET_PTS : DOT_PTS) : 6'd0;
          if (eat_hit_now && (dots_q != 10'd0)) begin
            dots_q <= dots_q - 10'd1;
            if (dots_q == 10'd1) level_clear_q <= 1'b1;
          end
        end
        EAT_WR:  state_q <= RUN;
        default: state_q <= SEED;
      endcase
    end
  end

  assign bus.rom_row        = seed_tile_q.row;
  assign bus.rom_col        = seed_tile_q.col;
  assign bus.render_dot     = ram_rdata & render_vld_q;
  assign bus.eat_ack        = ack_q;
  assign bus.eat_hit        = hit_q;
  assign bus.eat_power      = power_q;
  assign bus.eat_points     = points_q;
  assign bus.dots_remaining = dots_q;
  assign bus.level_clear    = level_clear_q;
  assign bus.busy           = busy_q;
  assign bus.state          = state_q;
endmodule

// File: tb/tb_dot_ctrl.sv
// Bench for dot_ctrl: wall-ROM model, tile-map reference model and one task
// per scenario, all inputs driven and outputs sampled on the falling edge.
module tb_dot_ctrl;
  import dot_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  dot_ctrl_if bus ();
  dot_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rom_mode = 0;  // 0 border walls, 1 single open tile (5,5), 2 random
  bit rand_wall [0:30][0:27];
  bit dot_m [0:30][0:27];
  int count_m = 0;

  function automatic bit wall_at(int r, int c);
    if (r >= 31 || c >= 28) return 1'b1;
    case (rom_mode)
      0:       return (r == 0) || (r == 30) || (c == 0) || (c == 27);
      1:       return !((r == 5) && (c == 5));
      default: return rand_wall[r][c];
    endcase
  endfunction

  always @(posedge clk) bus.rom_wall <= wall_at(int'(bus.rom_row), int'(bus.rom_col));

  function automatic bit is_pel(int r, int c);
    return ((r == 3) || (r == 23)) && ((c == 1) || (c == 26));
  endfunction

  function automatic bit model_dot(int r, int c);
    if (r >= 31 || c >= 28) return 1'b0;
    return dot_m[r][c];
  endfunction

  task automatic seed_model();
    count_m = 0;
    for (int r = 0; r < 31; r++)
      for (int c = 0; c < 28; c++) begin
        dot_m[r][c] = !wall_at(r, c);
        count_m += int'(dot_m[r][c]);
      end
  endtask

  task automatic randomize_walls();
    for (int r = 0; r < 31; r++)
      for (int c = 0; c < 28; c++)
        rand_wall[r][c] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic model_eat(input int r, input int c, output bit hit, output bit pw, output int pts);
    hit = model_dot(r, c);
    pw  = hit && is_pel(r, c);
    pts = hit ? (pw ? 50 : 10) : 0;
    if (hit) begin
      dot_m[r][c] = 1'b0;
      count_m--;
    end
  endtask

  task automatic wait_seed(output int n, output bit rd_seen, output bit ack_seen);
    n = 0; rd_seen = 1'b0; ack_seen = 1'b0;
    while (bus.busy === 1'b1 && n < 2000) begin
      if (bus.render_dot !== 1'b0) rd_seen = 1'b1;
      if (bus.eat_ack !== 1'b0) ack_seen = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_eat(input int r, input int c, output int lat, output bit hit, output bit pw,
                        output int pts, output int dots, output bit clr, output bit extra_ack);
    bus.eat_row = 5'(r);
    bus.eat_col = 5'(c);
    bus.eat_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.eat_ack !== 1'b1 && lat < 50);
    hit  = bus.eat_hit;
    pw   = bus.eat_power;
    pts  = int'(bus.eat_points);
    dots = int'(bus.dots_remaining);
    clr  = bus.level_clear;
    bus.eat_req = 1'b0;
    @(negedge clk);
    extra_ack = bus.eat_ack;
  endtask

  task automatic do_render(input int r, input int c, output bit d);
    bus.render_en  = 1'b1;
    bus.render_row = 5'(r);
    bus.render_col = 5'(c);
    @(negedge clk);
    d = bus.render_dot;
    bus.render_en = 1'b0;
  endtask

  task automatic test_reset();
    int n; bit rd, ak;
    rom_mode = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
    checks++; if (bus.dots_remaining !== 10'd0 || bus.level_clear !== 1'b0) begin
      errors++; $display("FAIL reset_count: dots %0d clear %b want 0 0", bus.dots_remaining, bus.level_clear); end
    checks++; if ({bus.eat_ack, bus.eat_hit, bus.eat_power, bus.eat_points, bus.render_dot} !== 10'd0) begin
      errors++; $display("FAIL reset_outputs: ack %b hit %b pw %b pts %0d rd %b want all 0",
                         bus.eat_ack, bus.eat_hit, bus.eat_power, bus.eat_points, bus.render_dot); end
    checks++; if (bus.state !== SEED) begin errors++; $display("FAIL reset_state: got %0d want SEED", bus.state); end
    bus.render_en = 1'b1; bus.render_row = 5'd1; bus.render_col = 5'd1;
    reset = 1'b0;
    wait_seed(n, rd, ak);
    bus.render_en = 1'b0;
    seed_model();
    checks++; if (n != 869) begin errors++; $display("FAIL seed_cycles: got %0d want 869", n); end
    checks++; if (int'(bus.dots_remaining) != count_m) begin
      errors++; $display("FAIL seed_count: got %0d want %0d", bus.dots_remaining, count_m); end
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL seed_render: got render_dot 1 want 0"); end
    checks++; if (bus.level_clear !== 1'b0) begin errors++; $display("FAIL seed_clear: got %b want 0", bus.level_clear); end
  endtask

  task automatic test_eat();
    int lat, pts, dots, epts; bit hit, pw, clr, ex, eh, ep;
    for (int k = 0; k < 2; k++) begin
      do_eat(1, 1, lat, hit, pw, pts, dots, clr, ex);
      model_eat(1, 1, eh, ep, epts);
      checks++; if (lat != 2) begin errors++; $display("FAIL eat_latency[%0d]: got %0d want 2", k, lat); end
      checks++; if (hit !== eh || pw !== ep || pts != epts) begin
        errors++; $display("FAIL eat_result[%0d]: hit %b pw %b pts %0d want %b %b %0d", k, hit, pw, pts, eh, ep, epts); end
      checks++; if (dots != count_m) begin errors++; $display("FAIL eat_count[%0d]: got %0d want %0d", k, dots, count_m); end
      checks++; if (ex !== 1'b0) begin errors++; $display("FAIL eat_ack_width[%0d]: got ack 1 after ack cycle want 0", k); end
    end
  endtask

  task automatic test_pellet();
    int lat, pts, dots, epts; bit hit, pw, clr, ex, eh, ep, d;
    do_eat(3, 1, lat, hit, pw, pts, dots, clr, ex);
    model_eat(3, 1, eh, ep, epts);
    checks++; if (lat != 2 || hit !== eh || pw !== ep || pts != epts || dots != count_m) begin
      errors++; $display("FAIL pellet_eat: lat %0d hit %b pw %b pts %0d dots %0d want 2 %b %b %0d %0d",
                         lat, hit, pw, pts, dots, eh, ep, epts, count_m); end
    do_render(3, 1, d);
    checks++; if (d !== model_dot(3, 1)) begin errors++; $display("FAIL pellet_render_eaten: got %b want %b", d, model_dot(3, 1)); end
    do_render(3, 26, d);
    checks++; if (d !== model_dot(3, 26)) begin errors++; $display("FAIL pellet_render_live: got %b want %b", d, model_dot(3, 26)); end
  endtask

  task automatic test_render_block();
    int pr, pc, bad_rd, lat, pts, dots, epts; bit acked, hit, pw, clr, ex, eh, ep;
    bus.eat_row = 5'd2; bus.eat_col = 5'd2; bus.eat_req = 1'b1;
    pr = $urandom_range(0, 31); pc = $urandom_range(0, 31);
    bus.render_en = 1'b1; bus.render_row = 5'(pr); bus.render_col = 5'(pc);
    bad_rd = 0; acked = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.eat_ack !== 1'b0) acked = 1'b1;
      if (bus.render_dot !== model_dot(pr, pc)) bad_rd++;
      pr = $urandom_range(0, 31); pc = $urandom_range(0, 31);
      bus.render_row = 5'(pr); bus.render_col = 5'(pc);
    end
    bus.render_en = 1'b0;
    checks++; if (acked !== 1'b0) begin errors++; $display("FAIL block_no_ack: got ack while render_en high want none"); end
    checks++; if (bad_rd != 0) begin errors++; $display("FAIL block_render_data: got %0d wrong render_dot want 0", bad_rd); end
    do_eat(2, 2, lat, hit, pw, pts, dots, clr, ex);
    model_eat(2, 2, eh, ep, epts);
    checks++; if (lat != 2 || hit !== eh || pts != epts || dots != count_m) begin
      errors++; $display("FAIL block_release: lat %0d hit %b pts %0d dots %0d want 2 %b %0d %0d",
                         lat, hit, pts, dots, eh, epts, count_m); end
  endtask

  task automatic test_back_to_back();
    int n, r, c, lat, pts, dots, epts, bad_rd; bit rd, ak, hit, pw, clr, ex, eh, ep, d;
    rom_mode = 2;
    randomize_walls();
    bus.level_restart = 1'b1;
    @(negedge clk);
    bus.level_restart = 1'b0;
    wait_seed(n, rd, ak);
    seed_model();
    checks++; if (n != 869 || int'(bus.dots_remaining) != count_m) begin
      errors++; $display("FAIL rand_seed: cycles %0d dots %0d want 869 %0d", n, bus.dots_remaining, count_m); end
    for (int i = 0; i < 40; i++) begin
      if (i < 4) begin r = (i < 2) ? 3 : 23; c = (i % 2 == 0) ? 1 : 26; end
      else if ($urandom_range(0, 9) < 8) begin r = $urandom_range(0, 30); c = $urandom_range(0, 27); end
      else begin r = $urandom_range(0, 31); c = $urandom_range(0, 31); end
      do_eat(r, c, lat, hit, pw, pts, dots, clr, ex);
      model_eat(r, c, eh, ep, epts);
      checks++; if (lat != 2 || hit !== eh || pw !== ep || pts != epts || dots != count_m || ex !== 1'b0) begin
        errors++; $display("FAIL rand_eat[%0d] (%0d,%0d): lat %0d hit %b pw %b pts %0d dots %0d ex %b want 2 %b %b %0d %0d 0",
                           i, r, c, lat, hit, pw, pts, dots, ex, eh, ep, epts, count_m); end
    end
    bad_rd = 0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 31); c = $urandom_range(0, 31);
      do_render(r, c, d);
      if (d !== model_dot(r, c)) bad_rd++;
    end
    checks++; if (bad_rd != 0) begin errors++; $display("FAIL rand_render: got %0d wrong reads want 0", bad_rd); end
  endtask

  task automatic test_level_clear();
    int n, lat, pts, dots, epts; bit rd, ak, hit, pw, clr, ex, eh, ep;
    rom_mode = 1;
    bus.level_restart = 1'b1;
    @(negedge clk);
    bus.level_restart = 1'b0;
    wait_seed(n, rd, ak);
    seed_model();
    checks++; if (n != 869 || int'(bus.dots_remaining) != count_m) begin
      errors++; $display("FAIL single_seed: cycles %0d dots %0d want 869 %0d", n, bus.dots_remaining, count_m); end
    do_eat(5, 5, lat, hit, pw, pts, dots, clr, ex);
    model_eat(5, 5, eh, ep, epts);
    checks++; if (hit !== eh || dots != count_m || clr !== (count_m == 0)) begin
      errors++; $display("FAIL clear_on_ack: hit %b dots %0d clear %b want %b %0d %b", hit, dots, clr, eh, count_m, count_m == 0); end
    repeat (5) @(negedge clk);
    checks++; if (bus.level_clear !== 1'b1) begin errors++; $display("FAIL clear_sticky: got %b want 1", bus.level_clear); end
    do_eat(5, 5, lat, hit, pw, pts, dots, clr, ex);
    model_eat(5, 5, eh, ep, epts);
    checks++; if (hit !== eh || pts != epts || dots != count_m || clr !== 1'b1) begin
      errors++; $display("FAIL clear_no_underflow: hit %b pts %0d dots %0d clear %b want %b %0d %0d 1",
                         hit, pts, dots, clr, eh, epts, count_m); end
    bus.level_restart = 1'b1;
    @(negedge clk);
    bus.level_restart = 1'b0;
    checks++; if (bus.level_clear !== 1'b0 || bus.dots_remaining !== 10'd0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL restart_clears: clear %b dots %0d busy %b want 0 0 1", bus.level_clear, bus.dots_remaining, bus.busy); end
    wait_seed(n, rd, ak);
    seed_model();
    checks++; if (n != 869 || int'(bus.dots_remaining) != count_m || bus.level_clear !== 1'b0) begin
      errors++; $display("FAIL restart_reseed: cycles %0d dots %0d clear %b want 869 %0d 0",
                         n, bus.dots_remaining, bus.level_clear, count_m); end
  endtask

  task automatic test_restart_abort();
    int n, lat, bad_rd; bit rd, ak, d;
    rom_mode = 2;
    randomize_walls();
    bus.eat_row = 5'd5; bus.eat_col = 5'd5; bus.eat_req = 1'b1;
    @(negedge clk);
    checks++; if (bus.state !== EAT_RD) begin errors++; $display("FAIL abort_in_eat_rd: state %0d want EAT_RD", bus.state); end
    bus.level_restart = 1'b1;
    bus.eat_req = 1'b0;
    @(negedge clk);
    bus.level_restart = 1'b0;
    checks++; if (bus.eat_ack !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL abort_no_ack: ack %b busy %b want 0 1", bus.eat_ack, bus.busy); end
    bus.eat_row = 5'd31; bus.eat_col = 5'd5; bus.eat_req = 1'b1;
    wait_seed(n, rd, ak);
    seed_model();
    checks++; if (n != 869 || ak !== 1'b0) begin
      errors++; $display("FAIL abort_reseed: cycles %0d ack_during_seed %b want 869 0", n, ak); end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.eat_ack !== 1'b1 && lat < 50);
    checks++; if (lat != 2 || bus.eat_hit !== 1'b0 || bus.eat_points !== 6'd0 || int'(bus.dots_remaining) != count_m) begin
      errors++; $display("FAIL oob_eat: lat %0d hit %b pts %0d dots %0d want 2 0 0 %0d",
                         lat, bus.eat_hit, bus.eat_points, bus.dots_remaining, count_m); end
    bus.eat_req = 1'b0;
    @(negedge clk);
    bad_rd = 0;
    for (int r = 0; r < 31; r++)
      for (int c = 0; c < 28; c++) begin
        do_render(r, c, d);
        if (d !== dot_m[r][c]) bad_rd++;
      end
    checks++; if (bad_rd != 0) begin errors++; $display("FAIL abort_full_map: got %0d wrong tiles want 0", bad_rd); end
  endtask

  initial begin
    bus.level_restart = 1'b0;
    bus.render_en = 1'b0; bus.render_row = '0; bus.render_col = '0;
    bus.eat_req = 1'b0; bus.eat_row = '0; bus.eat_col = '0;
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_eat();
    test_pellet();
    test_render_block();
    test_back_to_back();
    test_level_clear();
    test_restart_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
